pipelined_addsub: RTL and testbench

- Parametrised successor to the 32-bit ripple Add block: a WIDTH-bit adder/subtractor whose carry chain is split into SEG-bit segments, one pipeline stage per segment.
- Supports add and subtract modes and produces CF, OF, ZF and SF flags.
- Uses a valid/ready handshake on input and output, with full back-pressure.
- Sits between the register-file read stage and the ALU result mux wherever a high-clock-rate add is needed.

---
 rtl/pipelined_addsub.sv | 128 ++++++++++++
 tb/tb_pipelined_addsub.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit adder/subtractor with its carry chain cut into
// SEG-bit segments, one pipeline stage per segment. A valid/ready handshake
// with full back-pressure sits on both ends. When the consumer stalls, every
// stage holds its contents.
//
// Stage i adds operand segment i to the registered carry from stage i-1.
// Stage 0 uses the effective carry-in. In subtract mode the second operand
// and the carry-in are inverted once, in stage 0, before the first segment
// add. The inverted operand then travels down the pipe.
//
// Each stage register carries:
//   - the full (already inverted) operands, so that the upper segments meet
//     their carry in a later stage;
//   - the partial result, whose lower segments are already final.
//
// The last stage also captures the carry into the MSB, which is used for the
// signed-overflow flag.

module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sr,
  input  logic [WIDTH-1:0] tg,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             CF,
  output logic             OF,
  output logic             ZF,
  output logic             SF
);

  localparam int NST = WIDTH / SEG;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  logic [NST-1:0]   vld;
  logic [NST-1:0]   cy_r;
  logic [WIDTH-1:0] a_r   [NST];
  logic [WIDTH-1:0] b_r   [NST];
  logic [WIDTH-1:0] sum_r [NST];
  logic             msbc_r;
  logic             zf_r;

  logic [SEG-1:0]   seg_a   [NST];
  logic [SEG-1:0]   seg_b   [NST];
  logic [NST-1:0]   seg_c;
  logic [SEG:0]     seg_sum [NST];
  logic [WIDTH-1:0] sum_nxt [NST];

  // Segment adders: stage 0 takes the live inputs, later stages take their
  // operands from the previous stage register.
  always_comb begin
    b_eff    = op ? ~tg  : tg;
    c_eff    = op ? ~cin : cin;
    seg_a[0] = sr[SEG-1:0];
    seg_b[0] = b_eff[SEG-1:0];
    seg_c[0] = c_eff;
    for (int i = 1; i < NST; i++) begin
      seg_a[i] = a_r[i-1][i*SEG +: SEG];
      seg_b[i] = b_r[i-1][i*SEG +: SEG];
      seg_c[i] = cy_r[i-1];
    end
    for (int i = 0; i < NST; i++) begin
      seg_sum[i] = {1'b0, seg_a[i]} + {1'b0, seg_b[i]} + {{SEG{1'b0}}, seg_c[i]};
      if (i == 0) begin
        sum_nxt[i] = '0;
      end else begin
        sum_nxt[i] = sum_r[i-1];
      end
      sum_nxt[i][i*SEG +: SEG] = seg_sum[i][SEG-1:0];
    end
  end

  // Stage registers: the whole pipe shifts together, and only when the
  // output end can move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld    <= '0;
      cy_r   <= '0;
      msbc_r <= 1'b0;
      zf_r   <= 1'b0;
      for (int i = 0; i < NST; i++) begin
        a_r[i]   <= '0;
        b_r[i]   <= '0;
        sum_r[i] <= '0;
      end
    end else if (advance) begin
      vld[0] <= in_valid;
      a_r[0] <= sr;
      b_r[0] <= b_eff;
      for (int i = 1; i < NST; i++) begin
        vld[i] <= vld[i-1];
        a_r[i] <= a_r[i-1];
        b_r[i] <= b_r[i-1];
      end
      for (int i = 0; i < NST; i++) begin
        sum_r[i] <= sum_nxt[i];
        cy_r[i]  <= seg_sum[i][SEG];
      end
      // Carry into the MSB: the sum bit XOR both operand bits.
      msbc_r <= seg_sum[NST-1][SEG-1] ^ seg_a[NST-1][SEG-1] ^ seg_b[NST-1][SEG-1];
      zf_r   <= (sum_nxt[NST-1] == '0);
    end
  end

  // Handshake and result/flag outputs, all taken from the last stage.
  always_comb begin
    out_valid = vld[NST-1];
    advance   = !out_valid || out_ready;
    in_ready  = advance;
    res       = sum_r[NST-1];
    CF        = cy_r[NST-1];
    OF        = cy_r[NST-1] ^ msbc_r;
    ZF        = zf_r;
    SF        = sum_r[NST-1][WIDTH-1];
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed vectors with literal expectations, plus an
// arithmetic reference model and a scoreboard that checks every output
// transfer, the in_ready rule and output stability during stalls. It also
// drives two extra instances, WIDTH=16/SEG=4 and WIDTH=32/SEG=32.

module tb_pipelined_addsub;

  localparam int NST = 4;

  typedef struct packed {
    logic [31:0] res;
    logic        cf;
    logic        ovf;
    logic        zf;
    logic        sf;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] sr, tg, res;
  logic        cin, op, CF, OF, ZF, SF;

  logic        a16_in_valid, a16_in_ready, a16_out_valid;
  logic [15:0] a16_sr, a16_tg, a16_res;
  logic        a16_cf, a16_of, a16_zf, a16_sf;

  logic        a32_in_valid, a32_in_ready, a32_out_valid;
  logic [31:0] a32_sr, a32_tg, a32_res;
  logic        a32_cf, a32_of, a32_zf, a32_sf;

  int          tests = 0;
  int          fails = 0;
  exp_t        q[$];
  exp_t        mon_e;
  exp_t        snap;
  logic        stalled = 1'b0;

  pipelined_addsub #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sr(sr), .tg(tg), .cin(cin), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .CF(CF), .OF(OF), .ZF(ZF), .SF(SF)
  );

  pipelined_addsub #(.WIDTH(16), .SEG(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(a16_in_valid), .in_ready(a16_in_ready),
    .sr(a16_sr), .tg(a16_tg), .cin(1'b0), .op(1'b0),
    .out_valid(a16_out_valid), .out_ready(1'b0),
    .res(a16_res), .CF(a16_cf), .OF(a16_of), .ZF(a16_zf), .SF(a16_sf)
  );

  pipelined_addsub #(.WIDTH(32), .SEG(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(a32_in_valid), .in_ready(a32_in_ready),
    .sr(a32_sr), .tg(a32_tg), .cin(1'b0), .op(1'b0),
    .out_valid(a32_out_valid), .out_ready(1'b0),
    .res(a32_res), .CF(a32_cf), .OF(a32_of), .ZF(a32_zf), .SF(a32_sf)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  // Reference result: plain wide arithmetic. Overflow is taken from the
  // operand and result signs.
  function automatic exp_t model(input logic o, input logic [31:0] a,
                                 input logic [31:0] b, input logic c);
    logic [32:0] full;
    logic [31:0] be;
    logic        ce;
    exp_t        e;
    be    = o ? ~b : b;
    ce    = o ? ~c : c;
    full  = {1'b0, a} + {1'b0, be} + {32'd0, ce};
    e.res = full[31:0];
    e.cf  = full[32];
    e.ovf = (a[31] == be[31]) && (e.res[31] != a[31]);
    e.zf  = (e.res == 32'd0);
    e.sf  = e.res[31];
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present one operand set for a single accept edge, then count the edges
  // until out_valid appears.
  task automatic applyStimulus(input logic o, input logic [31:0] a,
                               input logic [31:0] b, input logic c,
                               output int lat);
    @(posedge clk); #1;
    op = o; sr = a; tg = b; cin = c; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Scoreboard, evaluated mid-cycle, once the inputs have settled for the
  // coming edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stalled = 1'b0;
    end else begin
      checkOutput("in_ready_rule", in_ready, !out_valid || out_ready);
      if (stalled && out_valid)
        checkOutput("stall_hold", {res, CF, OF, ZF, SF}, snap);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_output: got res %0h, expected no output", res);
        end else begin
          mon_e = q.pop_front();
          checkOutput("model_res", res, mon_e.res);
          checkOutput("model_flags", {CF, OF, ZF, SF},
                      {mon_e.cf, mon_e.ovf, mon_e.zf, mon_e.sf});
        end
      end
      if (in_valid && in_ready) q.push_back(model(op, sr, tg, cin));
      stalled = out_valid && !out_ready;
      snap    = {res, CF, OF, ZF, SF};
    end
  end

  // Stimulus sequence.
  initial begin
    int   lat, idx, cyc, n, stray, n16, n32;
    logic acc;
    logic        rop  [8];
    logic [31:0] rsr  [8];
    logic [31:0] rtg  [8];
    logic        rcin [8];

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; sr = '0; tg = '0; cin = 1'b0; op = 1'b0;
    a16_in_valid = 1'b0; a16_sr = '0; a16_tg = '0;
    a32_in_valid = 1'b0; a32_sr = '0; a32_tg = '0;
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_res", res, 0);
    checkOutput("reset_flags", {CF, OF, ZF, SF}, 4'b0000);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_in_ready16", a16_in_ready, 1);
    checkOutput("reset_in_ready32", a32_in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors; flags are listed as {CF,OF,ZF,SF}.
    applyStimulus(1'b0, 32'h7FFFFFFF, 32'h1, 1'b0, lat);
    checkOutput("ovf_latency", lat, NST - 1);
    checkOutput("ovf_res", res, 32'h80000000);
    checkOutput("ovf_flags", {CF, OF, ZF, SF}, 4'b0101);

    applyStimulus(1'b0, 32'hFFFFFFFF, 32'h1, 1'b0, lat);
    checkOutput("ripple_latency", lat, NST - 1);
    checkOutput("ripple_res", res, 32'h0);
    checkOutput("ripple_flags", {CF, OF, ZF, SF}, 4'b1010);

    applyStimulus(1'b1, 32'h5, 32'h7, 1'b0, lat);
    checkOutput("sub_neg_res", res, 32'hFFFFFFFE);
    checkOutput("sub_neg_flags", {CF, OF, ZF, SF}, 4'b0001);

    applyStimulus(1'b1, 32'h80000000, 32'h1, 1'b0, lat);
    checkOutput("sub_ovf_res", res, 32'h7FFFFFFF);
    checkOutput("sub_ovf_flags", {CF, OF, ZF, SF}, 4'b1100);

    applyStimulus(1'b1, 32'hA, 32'h3, 1'b1, lat);
    checkOutput("sub_borrow_in_res", res, 32'h6);
    checkOutput("sub_borrow_in_flags", {CF, OF, ZF, SF}, 4'b1000);

    applyStimulus(1'b0, 32'hFF, 32'h1, 1'b1, lat);
    checkOutput("add_cin_res", res, 32'h101);
    checkOutput("add_cin_flags", {CF, OF, ZF, SF}, 4'b0000);

    // Random stream with in_valid held high and out_ready cycling 1,0,0,1.
    for (int i = 0; i < 8; i++) begin
      rop[i]  = 1'($urandom % 2);
      rsr[i]  = $urandom;
      rtg[i]  = $urandom;
      rcin[i] = 1'($urandom % 2);
    end
    idx = 0;
    cyc = 0;
    @(posedge clk);
    while (idx < 8 && cyc < 200) begin
      #1;
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = 1'b1;
      op = rop[idx]; sr = rsr[idx]; tg = rtg[idx]; cin = rcin[idx];
      #1;
      acc = in_ready;
      @(posedge clk);
      if (acc) idx++;
      cyc++;
    end
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("stream_issued", idx, 8);
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("stream_drained", q.size(), 0);
    checkOutput("stream_idle", out_valid, 0);

    // Reset mid-flight: three operations accepted, the first one visible.
    @(posedge clk); #1;
    in_valid = 1'b1; op = 1'b0; tg = 32'h1; cin = 1'b0; sr = 32'h1; out_ready = 1'b1;
    @(posedge clk); #1;
    sr = 32'h2;
    @(posedge clk); #1;
    sr = 32'h3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("pre_reset_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_valid", out_valid, 0);
    checkOutput("async_reset_res", res, 0);
    #4;
    rst = 1'b0;
    stray = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) stray++;
    end
    checkOutput("no_stale_results", stray, 0);
    applyStimulus(1'b0, 32'h2, 32'h3, 1'b0, lat);
    checkOutput("post_reset_latency", lat, NST - 1);
    checkOutput("post_reset_res", res, 32'h5);

    // Other elaborations: 16/4 (four stages) and 32/32 (one stage).
    @(posedge clk); #1;
    a16_sr = 16'hFFFF; a16_tg = 16'h1; a16_in_valid = 1'b1;
    a32_sr = 32'hFFFFFFFF; a32_tg = 32'h1; a32_in_valid = 1'b1;
    @(posedge clk); #1;
    a16_in_valid = 1'b0;
    a32_in_valid = 1'b0;
    n16 = -1;
    n32 = -1;
    for (int k = 0; k < 20; k++) begin
      if (n16 < 0 && a16_out_valid) n16 = k;
      if (n32 < 0 && a32_out_valid) n32 = k;
      if (n16 >= 0 && n32 >= 0) break;
      @(posedge clk); #1;
    end
    checkOutput("w16_latency", n16, 3);
    checkOutput("w16_res", a16_res, 16'h0);
    checkOutput("w16_flags", {a16_cf, a16_of, a16_zf, a16_sf}, 4'b1010);
    checkOutput("w32s32_latency", n32, 0);
    checkOutput("w32s32_res", a32_res, 32'h0);
    checkOutput("w32s32_flags", {a32_cf, a32_of, a32_zf, a32_sf}, 4'b1010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
